// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request/response bundle between a pipeline (master) and the iterative
// RV32M multiply/divide sequencer (slave).
//   start   : request to begin one operation
//   funct3  : operation select (MUL..REMU)
//   op_a    : rs1 operand (multiplicand / dividend)
//   op_b    : rs2 operand (multiplier / divisor)
//   flush   : abort an in-flight operation
//   busy    : sequencer is iterating (stall source)
//   done    : one-cycle pulse, result valid
//   result  : registered result, held until the next done
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative RV32M multiply/divide unit. One bit is processed per BUSY cycle:
// shift-add multiply and restoring divide, both on operand magnitudes, with
// the sign applied to the final value. Divide-by-zero and signed overflow
// bypass the iteration and complete on the next edge.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset (priority over flush and start)
//   bus  : muldiv_if slave (start/funct3/op_a/op_b/flush in,
//          busy/done/result out)
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  // Latched operation context
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opnd_q;    // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q;      // product high half / partial remainder
  logic [XLEN-1:0] lo_q;      // multiplier / quotient shift register
  logic            neg_q;     // negate product or quotient at the end
  logic            neg_r_q;   // negate remainder at the end
  logic [XLEN-1:0] result_q;

  // ---------------------------------------------------------------------------
  // Request decode (operates on live inputs, used only on the accepting edge)
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            is_div;
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, overflow, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;   // MULHSU: signed x unsigned
      default: ;
    endcase
  end

  // Start is never taken while iterating, and flush always wins over it.
  assign accept   = (state_q != BUSY) && bus.start && !bus.flush;
  assign is_div   = bus.funct3[2];
  assign a_neg    = a_signed & bus.op_a[XLEN-1];
  assign b_neg    = b_signed & bus.op_b[XLEN-1];
  assign mag_a    = a_neg ? -bus.op_a : bus.op_a;
  assign mag_b    = b_neg ? -bus.op_b : bus.op_b;
  assign div_zero = is_div && (bus.op_b == '0);
  assign overflow = is_div && !bus.funct3[0] &&
                    (bus.op_a == MIN_NEG) && (bus.op_b == '1);
  assign special  = div_zero || overflow;

  // funct3[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = bus.funct3[1] ? bus.op_a : '1;
    else          special_res = bus.funct3[1] ? '0 : MIN_NEG;
  end

  // ---------------------------------------------------------------------------
  // One iteration step and final sign correction
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic              rem_ge;
  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, final_res;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    rem_ge   = rem_sh >= {1'b0, opnd_q};
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (op_q[2]) begin
      // Restoring divide: shift in the next dividend bit, subtract if it fits.
      hi_nx = rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], rem_ge};
    end else begin
      // Shift-add multiply: the carry out of the add shifts into the top.
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod   = {hi_nx, lo_nx};
    prod_s = neg_q   ? -prod  : prod;
    quot_s = neg_q   ? -lo_nx : lo_nx;
    rem_s  = neg_r_q ? -hi_nx : hi_nx;

    case (op_q)
      3'b000:                 final_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quot_s;
      default:                final_res = rem_s;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = special ? DONE : BUSY;
        else        state_d = IDLE;
      end
      BUSY: begin
        if (bus.flush)          state_d = IDLE;
        else if (cnt_q == LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: decoded from the next state, flopped above.
  always_comb begin
    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the datapath is plain flops, not a memory, so it is reset along
    // with the FSM and an aborted operation leaves nothing behind.
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= bus.funct3;
      cnt_q   <= '0;
      neg_q   <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      hi_q    <= '0;
      if (is_div) begin
        lo_q   <= mag_a;
        opnd_q <= mag_b;
      end else begin
        lo_q   <= mag_b;
        opnd_q <= mag_a;
      end
      if (special) result_q <= special_res;
    end else if (state_q == BUSY && !bus.flush) begin
      cnt_q <= cnt_q + 1'b1;
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      if (cnt_q == LAST) result_q <= final_res;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer: directed vector table, random
// operations against an arithmetic reference model, and hand-written
// sequences for flush, reset, and back-to-back starts.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_exp = '0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic and SV division semantics.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb;            return p[31:0];  end
      3'd1: begin p = sa * sb;            return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;            return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Waits (bounded) for done; lat counts negedges since the accepting edge.
  task automatic wait_done(input bit keep_start, input bit garbage, output int lat,
                           output logic [31:0] res, output int busy_n);
    lat    = -1;
    busy_n = 0;
    res    = '0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (!keep_start) bus.start = 1'b0;
      if (garbage) begin
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.funct3 = 3'($urandom);
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = n;
        res = bus.result;
        break;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input bit garbage);
    int          lat, busy_n;
    logic [31:0] res;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    wait_done(1'b0, garbage, lat, res, busy_n);
    check({name, " result"}, res, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy_cycles"}, 32'(busy_n), (exp_lat == 1) ? 32'd0 : 32'd32);
    @(negedge clk);
    check({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int          lat, busy_n, dones;
    logic [31:0] res;
    logic [2:0]  f;
    logic [31:0] a, b;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7_m3"});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "mulh_min"});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max"});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1"});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div_m7_2"});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2"});
    vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        33, "divu_100_7"});
    vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         33, "remu_100_7"});
    vecs.push_back('{3'd4, 32'd7,          32'd0,         32'hFFFF_FFFF,  1, "div_by0"});
    vecs.push_back('{3'd6, 32'd7,          32'd0,         32'd7,          1, "rem_by0"});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  1, "div_ovf"});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          1, "rem_ovf"});
    vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF,  1, "divu_by0"});
    vecs.push_back('{3'd7, 32'd5,          32'd0,         32'd5,          1, "remu_by0"});
    vecs.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33, "divu_ovf_pat"});

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    repeat (3) @(negedge clk);
    check("reset busy",   32'(bus.busy), 32'd0);
    check("reset done",   32'(bus.done), 32'd0);
    check("reset result", bus.result,    32'd0);

    // Start is presented in the same cycle reset drops.
    rst        = 1'b0;
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("accept_after_rst busy", 32'(bus.busy), 32'd1);
    wait_done(1'b0, 1'b0, lat, res, busy_n);
    check("accept_after_rst result",  res,        32'd15);
    check("accept_after_rst latency", 32'(lat),   32'd32);
    last_exp = 32'd15;

    foreach (vecs[i])
      check_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      check_op($sformatf("rand%0d f%0d", i, f), f, a, b, model(f, a, b),
               model_lat(f, a, b), 1'b1);
    end

    // Flush during the 10th BUSY cycle.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd123;
    bus.op_b   = 32'd456;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", 32'(bus.busy), 32'd0);
    check("flush done", 32'(bus.done), 32'd0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("flush no_done",   32'(dones), 32'd0);
    check("flush result",    bus.result, last_exp);
    check_op("after_flush", 3'd0, 32'd123, 32'd456, 32'd56088, 33, 1'b0);

    // Flush beats start, even for a would-be immediate divide-by-zero.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    bus.funct3 = 3'd5;
    bus.op_a   = 32'd9;
    bus.op_b   = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_vs_start busy", 32'(bus.busy), 32'd0);
    check("flush_vs_start done", 32'(bus.done), 32'd0);

    // Start held high with operands changing every cycle; second op taken in DONE.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd6;
    bus.op_b   = 32'd7;
    wait_done(1'b1, 1'b1, lat, res, busy_n);
    check("held_start result",  res,      32'd42);
    check("held_start latency", 32'(lat), 32'd33);
    bus.funct3 = 3'd5;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    wait_done(1'b0, 1'b1, lat, res, busy_n);
    check("back_to_back result",  res,      32'd14);
    check("back_to_back latency", 32'(lat), 32'd33);
    @(negedge clk);
    check("back_to_back done_one_cycle", 32'(bus.done), 32'd0);

    // Reset during the 20th BUSY cycle.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd0;
    bus.op_a   = 32'd1000;
    bus.op_b   = 32'd1000;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst busy",   32'(bus.busy), 32'd0);
    check("mid_rst done",   32'(bus.done), 32'd0);
    check("mid_rst result", bus.result,    32'd0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("mid_rst no_done", 32'(dones), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
